sram_controller: RTL and testbench

//  Bridges the MEM stage's single-cycle data-memory request (rd_en/wr_en, 32-bit address/data) to an external 16-bit asynchronous SRAM.

---
 rtl/sram_controller_if.sv | 19 +
 rtl/sram_controller.sv | 127 ++++++++++++
 tb/tb_sram_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Single-cycle data-memory request bus between the MEM stage (master) and the SRAM bridge (slave).
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Bridges a 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM as two wait-stated halves.
// ready stays low while an access is in flight so the pipeline freezes around it.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  sram_controller_if.slave   bus,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe_o,
  output logic               sram_we_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_ce_n_o
);

  localparam int unsigned      CNT_W   = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        read_data_q, read_data_d;

  logic [31:0]        offset;
  logic [SRAM_AW-2:0] wordIdx;
  logic               phaseDone;
  logic               hiHalf;
  logic               isRead;

  // Addresses below ADDR_BASE wrap modulo 2^32; upper word bits fall off the SRAM.
  assign offset    = bus.address - 32'(ADDR_BASE);
  assign wordIdx   = (SRAM_AW-1)'(offset >> 2);
  assign phaseDone = (cnt_q == CNT_MAX);
  assign hiHalf    = (state_q == RD_HI) || (state_q == WR_HI);
  assign isRead    = (state_q == RD_LO) || (state_q == RD_HI);

  assign bus.read_data = read_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    read_data_d  = read_data_q;
    bus.ready    = 1'b0;
    sram_addr_o  = '0;
    sram_dq_o    = '0;
    sram_dq_oe_o = 1'b0;
    sram_we_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_ce_n_o  = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A store wins over a simultaneous load; the load is dropped.
        if (bus.wr_en) begin
          state_d = WR_LO;
        end else if (bus.rd_en) begin
          state_d = RD_LO;
        end else begin
          bus.ready = 1'b1;
        end
      end

      RD_LO, RD_HI, WR_LO, WR_HI: begin
        sram_ce_n_o = 1'b0;
        sram_addr_o = {wordIdx, hiHalf};
        if (isRead) begin
          sram_oe_n_o = 1'b0;
        end else begin
          sram_we_n_o  = 1'b0;
          sram_dq_oe_o = 1'b1;
          sram_dq_o    = hiHalf ? bus.write_data[31:16] : bus.write_data[15:0];
        end

        if (phaseDone) begin
          cnt_d = '0;
          case (state_q)
            RD_LO: begin
              read_data_d[15:0] = sram_dq_i;
              state_d           = RD_HI;
            end
            RD_HI: begin
              read_data_d[31:16] = sram_dq_i;
              state_d            = DONE;
            end
            WR_LO:   state_d = WR_HI;
            default: state_d = DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        bus.ready = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: a transaction-level timing/memory model predicts every SRAM strobe,
// address, data and ready value each cycle; an SRAM array sits behind the DUT pins.
module tb_sram_controller;

  localparam int unsigned W     = 2;
  localparam int unsigned P     = W + 1;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned AW    = 18;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk  = 1'b0;
  logic          rstN = 1'b0;
  logic [AW-1:0] sramAddr;
  logic [15:0]   sramDqOut;
  logic [15:0]   sramDqIn;
  logic          sramDqOe;
  logic          sramWeN;
  logic          sramOeN;
  logic          sramCeN;

  sram_controller_if memBus();

  sram_controller #(
    .WAIT_CYCLES(W),
    .ADDR_BASE  (BASE),
    .SRAM_AW    (AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .bus         (memBus),
    .sram_addr_o (sramAddr),
    .sram_dq_o   (sramDqOut),
    .sram_dq_i   (sramDqIn),
    .sram_dq_oe_o(sramDqOe),
    .sram_we_n_o (sramWeN),
    .sram_oe_n_o (sramOeN),
    .sram_ce_n_o (sramCeN)
  );

  always #5 clk = ~clk;

  logic [15:0] sramMem [DEPTH];
  logic [15:0] refMem  [DEPTH];

  // The read mux returns a marker when the chip is not output-enabled, so a stray capture shows up.
  assign sramDqIn = (!sramCeN && !sramOeN) ? sramMem[sramAddr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!sramCeN && !sramWeN && sramDqOe) sramMem[sramAddr] <= sramDqOut;
  end

  int checks   = 0;
  int failures = 0;
  bit running  = 1'b1;

  bit          busy     = 1'b0;
  int unsigned k        = 0;
  bit          isWrite  = 1'b0;
  logic [31:0] reqAddr  = '0;
  logic [31:0] reqData  = '0;
  logic [31:0] expRead  = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int unsigned loAddrOf(input logic [31:0] a);
    logic [31:0] word;
    word = (a - 32'd1024) >> 2;
    return (word % (32'd1 << (AW - 1))) * 2;
  endfunction

  // Expected pin values for the current cycle, derived from how far into the access we are.
  task automatic compareCycle();
    int unsigned expAddr;
    logic [15:0] expDq;
    logic        expReady, expDqOe, expWeN, expOeN, expCeN, hi;
    if (!rstN) begin
      busy    = 1'b0;
      k       = 0;
      expRead = '0;
    end
    expAddr = 0; expDq = '0; expDqOe = 1'b0;
    expWeN = 1'b1; expOeN = 1'b1; expCeN = 1'b1;
    if (!busy) begin
      expReady = !(memBus.rd_en || memBus.wr_en);
    end else if (k == 2 * P + 1) begin
      expReady = 1'b1;
    end else begin
      expReady = 1'b0;
      hi       = (k > P);
      expAddr  = loAddrOf(reqAddr) + (hi ? 1 : 0);
      expCeN   = 1'b0;
      if (isWrite) begin
        expWeN  = 1'b0;
        expDqOe = 1'b1;
        expDq   = hi ? reqData[31:16] : reqData[15:0];
      end else begin
        expOeN = 1'b0;
      end
    end
    checkOutput("ready",     32'(memBus.ready),     32'(expReady));
    checkOutput("sram_addr", 32'(sramAddr),         expAddr);
    checkOutput("sram_dq",   32'(sramDqOut),        32'(expDq));
    checkOutput("dq_oe",     32'(sramDqOe),         32'(expDqOe));
    checkOutput("we_n",      32'(sramWeN),          32'(expWeN));
    checkOutput("oe_n",      32'(sramOeN),          32'(expOeN));
    checkOutput("ce_n",      32'(sramCeN),          32'(expCeN));
    checkOutput("read_data", memBus.read_data,      expRead);
  endtask

  task automatic advanceModel();
    int unsigned lo;
    if (!rstN) begin
      busy    = 1'b0;
      expRead = '0;
    end else if (!busy) begin
      if (memBus.rd_en || memBus.wr_en) begin
        busy    = 1'b1;
        k       = 1;
        isWrite = memBus.wr_en;
        reqAddr = memBus.address;
        reqData = memBus.write_data;
      end
    end else begin
      lo = loAddrOf(reqAddr);
      if (isWrite && k <= P)                 refMem[lo]     = reqData[15:0];
      else if (isWrite && k <= 2 * P)        refMem[lo + 1] = reqData[31:16];
      else if (!isWrite && k == P)           expRead[15:0]  = refMem[lo];
      else if (!isWrite && k == 2 * P)       expRead[31:16] = refMem[lo + 1];
      if (k == 2 * P + 1) busy = 1'b0;
      else                k++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (running) compareCycle();
      @(posedge clk);
      advanceModel();
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, output int lowCycles,
                               output int oeLow, output int weLow);
    @(negedge clk);
    memBus.rd_en      = rd;
    memBus.wr_en      = wr;
    memBus.address    = addr;
    memBus.write_data = data;
    lowCycles = 0; oeLow = 0; weLow = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (memBus.ready) break;
      lowCycles++;
      if (!sramOeN) oeLow++;
      if (!sramWeN) weLow++;
      @(negedge clk);
      #1;
    end
    if (!memBus.ready) checkOutput("readyTimeout", 32'(memBus.ready), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    memBus.rd_en = 1'b0;
    memBus.wr_en = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int low, oeLow, weLow, gap, sel;
    logic [31:0] addr;
    for (int i = 0; i < DEPTH; i++) begin
      sramMem[i] = '0;
      refMem[i]  = '0;
    end
    memBus.rd_en = 1'b0; memBus.wr_en = 1'b0;
    memBus.address = '0; memBus.write_data = '0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset ready",     32'(memBus.ready), 32'd1);
    checkOutput("reset read_data", memBus.read_data,  32'd0);
    checkOutput("reset ce_n",      32'(sramCeN),      32'd1);
    checkOutput("reset dq_oe",     32'(sramDqOe),     32'd0);
    checkOutput("reset addr",      32'(sramAddr),     32'd0);
    checkOutput("model wrap addr", loAddrOf(32'd1020), 32'h3FFFE);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h12345678, low, oeLow, weLow);
    checkOutput("t1 readyLow", low, 32'd7);
    checkOutput("t1 weLow", weLow, 32'd6);
    idleCycles(1);
    checkOutput("t1 word0", 32'(sramMem[0]), 32'h5678);
    checkOutput("t1 word1", 32'(sramMem[1]), 32'h1234);

    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, low, oeLow, weLow);
    checkOutput("t2 readyLow", low, 32'd7);
    checkOutput("t2 oeLow", oeLow, 32'd6);
    checkOutput("t2 read_data", memBus.read_data, 32'h12345678);
    idleCycles(3);
    checkOutput("t2 read_data held", memBus.read_data, 32'h12345678);

    applyStimulus(1'b0, 1'b1, 32'd1028, 32'hCAFEBABE, low, oeLow, weLow);
    idleCycles(1);
    checkOutput("t3 word2", 32'(sramMem[2]), 32'hBABE);
    checkOutput("t3 word3", 32'(sramMem[3]), 32'hCAFE);
    checkOutput("t3 word0", 32'(sramMem[0]), 32'h5678);
    checkOutput("t3 word1", 32'(sramMem[1]), 32'h1234);

    applyStimulus(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, low, oeLow, weLow);
    checkOutput("t4 weLow", weLow, 32'd6);
    checkOutput("t4 oeLow", oeLow, 32'd0);
    checkOutput("t4 read_data kept", memBus.read_data, 32'h12345678);
    idleCycles(1);
    checkOutput("t4 word0", 32'(sramMem[0]), 32'hA5A5);
    checkOutput("t4 word1", 32'(sramMem[1]), 32'hA5A5);

    applyStimulus(1'b0, 1'b1, 32'd1020, 32'hBEEF0123, low, oeLow, weLow);
    idleCycles(1);
    checkOutput("wrap lo", 32'(sramMem[18'h3FFFE]), 32'h0123);
    checkOutput("wrap hi", 32'(sramMem[18'h3FFFF]), 32'hBEEF);

    @(negedge clk);
    memBus.wr_en = 1'b1; memBus.address = 32'd1032; memBus.write_data = 32'h11112222;
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("t5 we_n", 32'(sramWeN), 32'd1);
    checkOutput("t5 dq_oe", 32'(sramDqOe), 32'd0);
    checkOutput("t5 read_data", memBus.read_data, 32'd0);
    idleCycles(1);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("t5 ready after release", 32'(memBus.ready), 32'd1);
    checkOutput("t5 partial lo", 32'(sramMem[4]), 32'h2222);
    checkOutput("t5 partial hi", 32'(sramMem[5]), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, low, oeLow, weLow);
    checkOutput("t5 readyLow", low, 32'd7);
    checkOutput("t5 read_data", memBus.read_data, 32'hA5A5A5A5);

    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0, low, oeLow, weLow);
    checkOutput("t6 first readyLow", low, 32'd7);
    checkOutput("t6 first read_data", memBus.read_data, 32'hCAFEBABE);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, low, oeLow, weLow);
    checkOutput("t6 second readyLow", low, 32'd7);
    checkOutput("t6 second read_data", memBus.read_data, 32'hA5A5A5A5);

    for (int n = 0; n < 60; n++) begin
      sel  = int'($urandom_range(0, 3));
      addr = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) addr = BASE - 4 * $urandom_range(1, 8);
      applyStimulus(sel != 1, sel == 1 || sel == 2, addr, $urandom, low, oeLow, weLow);
      checkOutput("rand readyLow", low, 32'd7);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idleCycles(gap);
    end

    idleCycles(2);
    running = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
